// File: rtl/iob_fp_pkg.sv
//------------------------------------------------------------------------------
// iob_fp_pkg : shared floating-point helpers (field widths, NaN/inf builders,
//              operand classification) for the iob FP arithmetic units.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package iob_fp_pkg;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  function automatic int fp_frac_w(input int data_w, input int exp_w);
    return data_w - exp_w - 1;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Builders return a 64-bit container; callers slice the low data_w bits.
  function automatic logic [63:0] fp_inf(input logic sign, input int data_w, input int exp_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << fp_frac_w(data_w, exp_w);
    r[data_w-1] = sign;
    return r;
  endfunction

  function automatic logic [63:0] fp_qnan(input int data_w, input int exp_w);
    return fp_inf(1'b0, data_w, exp_w) | (64'd1 << (fp_frac_w(data_w, exp_w) - 1));
  endfunction

  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    fp_class_t c;
    c.is_zero = exp_zero;
    c.is_inf  = exp_ones & frac_zero;
    c.is_nan  = exp_ones & ~frac_zero;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_fp_round_rne.sv
//------------------------------------------------------------------------------
// iob_fp_round_rne : combinational round-to-nearest-even on {mant, G, R, S}.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iob_fp_round_rne #(
  parameter int MW = 24,
  parameter int EW = 10
) (
  input  logic [MW-1:0]        mant_i,
  input  logic                 guard_i,
  input  logic                 round_i,
  input  logic                 sticky_i,
  input  logic signed [EW-1:0] exp_i,
  output logic [MW-1:0]        mant_o,
  output logic signed [EW-1:0] exp_o,
  output logic                 carry_o
);

  logic          inc;
  logic [MW:0]   sum;

  assign inc     = guard_i & (round_i | sticky_i | mant_i[0]);
  assign sum     = {1'b0, mant_i} + {{MW{1'b0}}, inc};
  assign carry_o = sum[MW];
  // A carry-out means the mantissa wrapped to 10..0; renormalise by one place.
  assign mant_o  = carry_o ? sum[MW:1] : sum[MW-1:0];
  assign exp_o   = exp_i + $signed({{(EW-1){1'b0}}, carry_o});

endmodule

`default_nettype wire

// File: rtl/iob_fp_mul_pipe.sv
//------------------------------------------------------------------------------
// iob_fp_mul_pipe : 4-stage pipelined FP multiplier, RNE, FTZ, valid/ready.
// Define IOB_FP_MUL_PIPE_SPECIAL_EN for NaN/inf/zero classification. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iob_fp_mul_pipe
  import iob_fp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] res_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              invalid_o
);

  localparam int FRAC_W = fp_frac_w(DATA_W, EXP_W);
  localparam int BIAS   = fp_bias(EXP_W);
  localparam int MW     = FRAC_W + 1;
  localparam int PW     = 2 * MW;
  localparam int EW     = EXP_W + 2;

  localparam logic [63:0]        QNAN64  = fp_qnan(DATA_W, EXP_W);
  localparam logic [63:0]        INFP64  = fp_inf(1'b0, DATA_W, EXP_W);
  localparam logic [63:0]        INFN64  = fp_inf(1'b1, DATA_W, EXP_W);
  localparam logic [DATA_W-1:0]  QNAN    = QNAN64[DATA_W-1:0];
  localparam logic [DATA_W-1:0]  INF_P   = INFP64[DATA_W-1:0];
  localparam logic [DATA_W-1:0]  INF_N   = INFN64[DATA_W-1:0];
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  // Stage registers
  logic                 v1_q, v2_q, v3_q, v4_q;
  logic                 sign1_q, sign2_q, sign3_q;
  logic signed [EW-1:0] exp1_q, exp2_q, exp3_q;
  logic [MW-1:0]        ma1_q, mb1_q, mant3_q;
  logic [PW-1:0]        prod2_q;
  logic                 g3_q, r3_q, stk3_q;
  fp_class_t            cls1_q, cls2_q, cls3_q;
  logic [TAG_W-1:0]     tag1_q, tag2_q, tag3_q, tag4_q;
  logic [DATA_W-1:0]    res4_q;
  logic                 ovf4_q, unf4_q, inv4_q;

  // Next-state values
  logic                 ld1, ld2, ld3, ld4;
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [FRAC_W-1:0]    a_frac, b_frac;
  logic signed [EW-1:0] exp1_d, exp3_d;
  fp_class_t            cls1_d;
  logic [PW-1:0]        prod2_d, norm3_d;
  logic [MW-1:0]        rmant;
  logic signed [EW-1:0] rexp;
  logic                 rcarry;
  logic [DATA_W-1:0]    res4_d;
  logic                 ovf4_d, unf4_d, inv4_d;

  // A stage loads when empty or when its occupant moves on this cycle.
  assign ld4        = ~v4_q | out_ready_i;
  assign ld3        = ~v3_q | ld4;
  assign ld2        = ~v2_q | ld3;
  assign ld1        = ~v1_q | ld2;
  assign in_ready_o = ld1;

  // S1: unpack and classify
  assign a_exp  = op_a_i[DATA_W-2 -: EXP_W];
  assign b_exp  = op_b_i[DATA_W-2 -: EXP_W];
  assign a_frac = op_a_i[FRAC_W-1:0];
  assign b_frac = op_b_i[FRAC_W-1:0];
  assign exp1_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(EW'(BIAS));

`ifdef IOB_FP_MUL_PIPE_SPECIAL_EN
  fp_class_t ca, cb;
  assign ca = fp_classify(a_exp == '0, a_exp == '1, a_frac == '0);
  assign cb = fp_classify(b_exp == '0, b_exp == '1, b_frac == '0);
  assign cls1_d.is_nan  = ca.is_nan | cb.is_nan | (ca.is_zero & cb.is_inf) | (ca.is_inf & cb.is_zero);
  assign cls1_d.is_inf  = ca.is_inf | cb.is_inf;
  assign cls1_d.is_zero = ca.is_zero | cb.is_zero;
`else
  logic unused_cls;
  assign cls1_d     = '0;
  assign unused_cls = ^cls3_q;
`endif

  // S2: significand product; S3: normalise so the hidden one sits at the MSB
  assign prod2_d = PW'(ma1_q) * PW'(mb1_q);
  assign norm3_d = prod2_q[PW-1] ? prod2_q : {prod2_q[PW-2:0], 1'b0};
  assign exp3_d  = exp2_q + $signed({{(EW-1){1'b0}}, prod2_q[PW-1]});

  iob_fp_round_rne #(.MW(MW), .EW(EW)) u_round (
    .mant_i   (mant3_q),
    .guard_i  (g3_q),
    .round_i  (r3_q),
    .sticky_i (stk3_q),
    .exp_i    (exp3_q),
    .mant_o   (rmant),
    .exp_o    (rexp),
    .carry_o  (rcarry)
  );

  // Hidden bit and carry are already folded into rexp/rmant by the rounder.
  logic unused_round;
  assign unused_round = rcarry ^ rmant[FRAC_W];

  // S4: saturate/flush, then special results override
  always_comb begin
    res4_d = {sign3_q, rexp[EXP_W-1:0], rmant[FRAC_W-1:0]};
    ovf4_d = 1'b0;
    unf4_d = 1'b0;
    inv4_d = 1'b0;
    if (rexp >= EXP_MAX) begin
      res4_d = sign3_q ? INF_N : INF_P;
      ovf4_d = 1'b1;
    end else if (rexp[EW-1] || rexp == '0) begin
      res4_d = {sign3_q, {(DATA_W-1){1'b0}}};
      unf4_d = 1'b1;
    end
`ifdef IOB_FP_MUL_PIPE_SPECIAL_EN
    if (cls3_q.is_nan) begin
      res4_d = QNAN;
      ovf4_d = 1'b0;
      unf4_d = 1'b0;
      inv4_d = 1'b1;
    end else if (cls3_q.is_inf) begin
      res4_d = sign3_q ? INF_N : INF_P;
      ovf4_d = 1'b0;
      unf4_d = 1'b0;
    end else if (cls3_q.is_zero) begin
      res4_d = {sign3_q, {(DATA_W-1){1'b0}}};
      ovf4_d = 1'b0;
      unf4_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      sign1_q <= 1'b0; sign2_q <= 1'b0; sign3_q <= 1'b0;
      exp1_q <= '0; exp2_q <= '0; exp3_q <= '0;
      ma1_q <= '0; mb1_q <= '0; mant3_q <= '0; prod2_q <= '0;
      g3_q <= 1'b0; r3_q <= 1'b0; stk3_q <= 1'b0;
      cls1_q <= '0; cls2_q <= '0; cls3_q <= '0;
      tag1_q <= '0; tag2_q <= '0; tag3_q <= '0; tag4_q <= '0;
      res4_q <= '0; ovf4_q <= 1'b0; unf4_q <= 1'b0; inv4_q <= 1'b0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          sign1_q <= op_a_i[DATA_W-1] ^ op_b_i[DATA_W-1];
          exp1_q  <= exp1_d;
          ma1_q   <= {1'b1, a_frac};
          mb1_q   <= {1'b1, b_frac};
          cls1_q  <= cls1_d;
          tag1_q  <= tag_i;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sign2_q <= sign1_q;
          exp2_q  <= exp1_q;
          prod2_q <= prod2_d;
          cls2_q  <= cls1_q;
          tag2_q  <= tag1_q;
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          sign3_q <= sign2_q;
          exp3_q  <= exp3_d;
          mant3_q <= norm3_d[PW-1 -: MW];
          g3_q    <= norm3_d[FRAC_W];
          r3_q    <= norm3_d[FRAC_W-1];
          stk3_q  <= |norm3_d[FRAC_W-2:0];
          cls3_q  <= cls2_q;
          tag3_q  <= tag2_q;
        end
      end
      if (ld4) begin
        v4_q <= v3_q;
        if (v3_q) begin
          res4_q <= res4_d;
          ovf4_q <= ovf4_d;
          unf4_q <= unf4_d;
          inv4_q <= inv4_d;
          tag4_q <= tag3_q;
        end
      end
    end
  end

  assign out_valid_o = v4_q;
  assign res_o       = res4_q;
  assign tag_o       = tag4_q;
  assign overflow_o  = ovf4_q;
  assign underflow_o = unf4_q;
  assign invalid_o   = inv4_q;

endmodule

`default_nettype wire
